// File: rtl/dma_desc_sched.sv
// dma_desc_sched: descriptor scheduler between the DMA CSR block and the DMA
// streamer. A go pulse makes it walk the enabled descriptor slots in ascending
// order. Each non-empty slot is offered over a valid/ready handshake, and the
// scheduler then waits for the streamer's completion pulse. Empty slots are
// marked complete without being issued. The first reported error is latched.
// Macros:
//   DMA_NUM_DESC      default slot count (2 when undefined)
//   DMA_ERR_ABORT_EN  when defined, the first captured error aborts the walk
//                     exactly like dma_abort_i; otherwise it is only recorded

`ifndef DMA_NUM_DESC
`define DMA_NUM_DESC 2
`endif

package dma_desc_sched_pkg;

  typedef enum logic [1:0] {
    DMA_NO_ERR     = 2'd0,
    DMA_AXI_RD_ERR = 2'd1,
    DMA_AXI_WR_ERR = 2'd2,
    DMA_ALIGN_ERR  = 2'd3
  } dma_err_t;

  typedef struct packed {
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] num_bytes;
  } s_dma_desc_t;

  typedef struct packed {
    logic        valid;
    dma_err_t    err_type;
    logic [31:0] addr;
  } s_dma_error_t;

  typedef struct packed {
    logic error;
    logic done;
    logic active;
  } s_dma_status_t;

endpackage

module dma_desc_sched
  import dma_desc_sched_pkg::*;
#(
  parameter int NUM_DESC = `DMA_NUM_DESC,
  parameter int IDX_W    = $clog2(NUM_DESC > 1 ? NUM_DESC : 2)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   dma_go_i,
  input  logic                                   dma_abort_i,
  input  logic [NUM_DESC*$bits(s_dma_desc_t)-1:0] dma_desc_i,
  input  logic [NUM_DESC-1:0]                    dma_desc_en_i,
  output logic                                   desc_valid_o,
  input  logic                                   desc_ready_i,
  output s_dma_desc_t                            desc_o,
  output logic [IDX_W-1:0]                       desc_idx_o,
  input  logic                                   str_done_i,
  input  s_dma_error_t                           str_err_i,
  output logic [NUM_DESC-1:0]                    desc_done_o,
  output s_dma_status_t                          status_o,
  output s_dma_error_t                           err_o
);

  localparam int               DESC_W   = $bits(s_dma_desc_t);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DESC - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } sched_st_t;

  // Registered state and outputs
  sched_st_t           state_r;
  logic [IDX_W-1:0]    idx_r;
  logic                desc_valid_r;
  s_dma_desc_t         desc_r;
  logic [IDX_W-1:0]    desc_idx_r;
  logic [NUM_DESC-1:0] desc_done_r;
  s_dma_status_t       status_r;
  s_dma_error_t        err_r;
  logic                abort_pend_r;

  // Next-state values
  sched_st_t           state_nxt_s;
  logic [IDX_W-1:0]    idx_nxt_s;
  logic                valid_nxt_s;
  s_dma_desc_t         desc_nxt_s;
  logic [IDX_W-1:0]    desc_idx_nxt_s;
  logic [NUM_DESC-1:0] done_nxt_s;
  s_dma_status_t       status_nxt_s;
  s_dma_error_t        err_nxt_s;
  logic                abort_pend_nxt_s;

  // Decoded helpers
  s_dma_desc_t         desc_arr_s [NUM_DESC];
  s_dma_desc_t         cur_desc_s;
  logic                cur_en_s;
  logic                cur_nonzero_s;
  logic                last_s;
  logic                go_acc_s;
  logic                err_cap_s;
  logic                abort_req_s;

  // Unpack the flat CSR descriptor bus into one entry per slot
  always_comb begin
    for (int i = 0; i < NUM_DESC; i++) begin
      desc_arr_s[i] = dma_desc_i[i*DESC_W +: DESC_W];
    end
  end

  assign cur_desc_s    = desc_arr_s[idx_r];
  assign cur_en_s      = dma_desc_en_i[idx_r];
  assign cur_nonzero_s = (cur_desc_s.num_bytes != 16'd0);
  assign last_s        = (idx_r == LAST_IDX);
  assign go_acc_s      = (state_r == ST_IDLE) && dma_go_i;
  // Only the first error of a run is kept; IDLE reports are ignored.
  assign err_cap_s     = (state_r != ST_IDLE) && str_err_i.valid && !err_r.valid;

`ifdef DMA_ERR_ABORT_EN
  // A captured error (or one being captured this cycle) behaves like abort.
  assign abort_req_s = dma_abort_i || err_r.valid || err_cap_s;
`else
  assign abort_req_s = dma_abort_i;
`endif

  // Scheduler next-state: slot walk, handshake and completion tracking
  always_comb begin
    state_nxt_s      = state_r;
    idx_nxt_s        = idx_r;
    valid_nxt_s      = desc_valid_r;
    desc_nxt_s       = desc_r;
    desc_idx_nxt_s   = desc_idx_r;
    done_nxt_s       = desc_done_r;
    abort_pend_nxt_s = abort_pend_r;
    case (state_r)
      ST_IDLE: begin
        if (go_acc_s) begin
          state_nxt_s      = ST_SCAN;
          idx_nxt_s        = '0;
          done_nxt_s       = '0;
          abort_pend_nxt_s = 1'b0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (abort_req_s) begin
          state_nxt_s = ST_DONE;
        end else if (cur_en_s && cur_nonzero_s) begin
          state_nxt_s    = ST_ISSUE;
          valid_nxt_s    = 1'b1;
          desc_nxt_s     = cur_desc_s;
          desc_idx_nxt_s = idx_r;
        end else begin
          // Empty enabled slots complete trivially; disabled ones stay 0.
          if (cur_en_s) begin
            done_nxt_s[idx_r] = 1'b1;
          end else begin
            done_nxt_s[idx_r] = desc_done_r[idx_r];
          end
          if (last_s) begin
            state_nxt_s = ST_DONE;
          end else begin
            idx_nxt_s = idx_r + IDX_W'(1);
          end
        end
      end
      ST_ISSUE: begin
        if (abort_req_s) begin
          state_nxt_s = ST_DONE;
          valid_nxt_s = 1'b0;
        end else if (desc_ready_i) begin
          state_nxt_s = ST_WAIT;
          valid_nxt_s = 1'b0;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        // An abort here is remembered; the in-flight transfer must finish.
        if (str_done_i) begin
          done_nxt_s[idx_r] = 1'b1;
          abort_pend_nxt_s  = 1'b0;
          if (abort_pend_r || abort_req_s || last_s) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_SCAN;
            idx_nxt_s   = idx_r + IDX_W'(1);
          end
        end else if (abort_req_s) begin
          abort_pend_nxt_s = 1'b1;
        end else begin
          abort_pend_nxt_s = abort_pend_r;
        end
      end
      ST_DONE: begin
        state_nxt_s      = ST_IDLE;
        abort_pend_nxt_s = 1'b0;
      end
      default: begin
        state_nxt_s      = ST_IDLE;
        valid_nxt_s      = 1'b0;
        abort_pend_nxt_s = 1'b0;
      end
    endcase
  end

  // First-error latch, cleared by an accepted go
  always_comb begin
    err_nxt_s = err_r;
    if (go_acc_s) begin
      err_nxt_s = '0;
    end else if (err_cap_s) begin
      err_nxt_s = str_err_i;
    end else begin
      err_nxt_s = err_r;
    end
  end

  // Status word derived from the next state so it lines up with the FSM
  always_comb begin
    status_nxt_s        = status_r;
    status_nxt_s.active = (state_nxt_s == ST_SCAN) || (state_nxt_s == ST_ISSUE) ||
                          (state_nxt_s == ST_WAIT);
    status_nxt_s.error  = err_nxt_s.valid;
    if (state_nxt_s == ST_DONE) begin
      status_nxt_s.done = 1'b1;
    end else if (go_acc_s) begin
      status_nxt_s.done = 1'b0;
    end else begin
      status_nxt_s.done = status_r.done;
    end
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      idx_r        <= '0;
      desc_valid_r <= 1'b0;
      desc_r       <= '0;
      desc_idx_r   <= '0;
      desc_done_r  <= '0;
      status_r     <= '0;
      err_r        <= '0;
      abort_pend_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      idx_r        <= idx_nxt_s;
      desc_valid_r <= valid_nxt_s;
      desc_r       <= desc_nxt_s;
      desc_idx_r   <= desc_idx_nxt_s;
      desc_done_r  <= done_nxt_s;
      status_r     <= status_nxt_s;
      err_r        <= err_nxt_s;
      abort_pend_r <= abort_pend_nxt_s;
    end
  end

  assign desc_valid_o = desc_valid_r;
  assign desc_o       = desc_r;
  assign desc_idx_o   = desc_idx_r;
  assign desc_done_o  = desc_done_r;
  assign status_o     = status_r;
  assign err_o        = err_r;

endmodule

// File: tb/tb_dma_desc_sched.sv
// Self-checking bench for dma_desc_sched with four descriptor slots.
// A streamer responder and a slot-list reference model live in run_job.
module tb_dma_desc_sched;
  import dma_desc_sched_pkg::*;

  localparam int ND = 4;
  localparam int DW = $bits(s_dma_desc_t);

  logic               clk = 1'b0;
  logic               rst;
  logic               dma_go_i;
  logic               dma_abort_i;
  logic [ND*DW-1:0]   dma_desc_i;
  logic [ND-1:0]      dma_desc_en_i;
  logic               desc_valid_o;
  logic               desc_ready_i;
  s_dma_desc_t        desc_o;
  logic [1:0]         desc_idx_o;
  logic               str_done_i;
  s_dma_error_t       str_err_i;
  logic [ND-1:0]      desc_done_o;
  s_dma_status_t      status_o;
  s_dma_error_t       err_o;

  int tests_run    = 0;
  int tests_failed = 0;

  s_dma_desc_t  cfg_desc [ND];
  logic [ND-1:0] cfg_en;

  always #5 clk = ~clk;

  dma_desc_sched #(.NUM_DESC(ND)) dut (
    .clk          (clk),
    .rst          (rst),
    .dma_go_i     (dma_go_i),
    .dma_abort_i  (dma_abort_i),
    .dma_desc_i   (dma_desc_i),
    .dma_desc_en_i(dma_desc_en_i),
    .desc_valid_o (desc_valid_o),
    .desc_ready_i (desc_ready_i),
    .desc_o       (desc_o),
    .desc_idx_o   (desc_idx_o),
    .str_done_i   (str_done_i),
    .str_err_i    (str_err_i),
    .desc_done_o  (desc_done_o),
    .status_o     (status_o),
    .err_o        (err_o)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_cfg();
    for (int i = 0; i < ND; i++) dma_desc_i[i*DW +: DW] = cfg_desc[i];
    dma_desc_en_i = cfg_en;
  endtask

  task automatic rand_desc(input int i, input int nbytes);
    cfg_desc[i].src_addr  = $urandom;
    cfg_desc[i].dst_addr  = $urandom;
    cfg_desc[i].num_bytes = 16'(nbytes);
  endtask

  // abort_mode: 0 none, 1 abort while first issue waits for ready, 2 abort in its WAIT.
  // err_pos: position in issue order whose WAIT receives two errors (-1 none).
  task automatic run_job(input string name, input int abort_mode, input int err_pos,
                         input int rdy_dly, input int done_dly, input bit go_noise,
                         input bit go_abort);
    int            issue_q[$];
    int            stop_pos;
    int            exp_offered;
    logic [ND-1:0] exp_mask;
    s_dma_error_t  err_a, err_b, exp_err;
    int            offered, phase, hold_cnt, wcnt;
    bit            finished;
    logic [1:0]    held_idx;
    s_dma_desc_t   held_desc;

    load_cfg();
    err_a.valid = 1'b1; err_a.err_type = DMA_AXI_RD_ERR; err_a.addr = 32'h0000_1000;
    err_b.valid = 1'b1; err_b.err_type = DMA_AXI_WR_ERR; err_b.addr = 32'h0000_2000;

    // Reference model: which slots get issued, where the run stops, final masks
    for (int i = 0; i < ND; i++)
      if (cfg_en[i] && cfg_desc[i].num_bytes != 16'd0) issue_q.push_back(i);
    stop_pos = -1;
    if (abort_mode != 0 && issue_q.size() > 0) stop_pos = 0;
`ifdef DMA_ERR_ABORT_EN
    if (err_pos >= 0 && err_pos < issue_q.size()) stop_pos = err_pos;
`endif
    exp_offered = (stop_pos < 0) ? issue_q.size() : stop_pos + 1;
    for (int i = 0; i < ND; i++) begin
      if (!cfg_en[i])                 exp_mask[i] = 1'b0;
      else if (stop_pos < 0)          exp_mask[i] = 1'b1;
      else if (i < issue_q[stop_pos]) exp_mask[i] = 1'b1;
      else if (i == issue_q[stop_pos]) exp_mask[i] = (abort_mode != 1);
      else                            exp_mask[i] = 1'b0;
    end
    exp_err = '0;
    if (err_pos >= 0 && err_pos < issue_q.size() && (stop_pos < 0 || err_pos <= stop_pos))
      exp_err = err_a;

    // Start the run
    @(negedge clk);
    dma_go_i = 1'b1; dma_abort_i = go_abort;
    @(negedge clk);
    dma_go_i = 1'b0; dma_abort_i = 1'b0;
    chk({name, "/go_status"}, status_o, 3'b001);
    chk({name, "/go_mask"}, desc_done_o, '0);
    chk({name, "/go_err"}, err_o, '0);
    chk({name, "/go_valid"}, desc_valid_o, 1'b0);
    @(negedge clk);
    chk({name, "/latency"}, desc_valid_o, (issue_q.size() > 0 && issue_q[0] == 0));

    offered = 0; phase = 0; hold_cnt = 0; wcnt = 0; finished = 0;
    held_idx = '0; held_desc = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (status_o.done) begin
        finished = 1;
        break;
      end
      chk({name, "/active"}, status_o.active, 1'b1);
      desc_ready_i = 1'b0; str_done_i = 1'b0; str_err_i = '0; dma_abort_i = 1'b0;
      dma_go_i = go_noise ? ($urandom_range(0, 7) == 0) : 1'b0;
      if (phase == 2) begin
        wcnt++;
        chk({name, "/wait_valid"}, desc_valid_o, 1'b0);
        if (wcnt == 1 && err_pos == offered - 1) str_err_i = err_a;
        if (wcnt == 2 && err_pos == offered - 1) str_err_i = err_b;
        if (wcnt == 1 && abort_mode == 2 && offered == 1) dma_abort_i = 1'b1;
        if (wcnt == done_dly) begin
          str_done_i = 1'b1;
          phase = 0;
        end
      end else if (phase == 0 && desc_valid_o) begin
        if (offered < issue_q.size()) begin
          chk({name, "/idx"}, desc_idx_o, issue_q[offered]);
          chk({name, "/desc"}, desc_o, cfg_desc[issue_q[offered]]);
        end else begin
          chk({name, "/extra_issue"}, 1'b1, 1'b0);
        end
        offered++;
        held_idx = desc_idx_o; held_desc = desc_o; hold_cnt = 0;
        phase = 1;
      end
      if (phase == 1) begin
        chk({name, "/hold_valid"}, desc_valid_o, 1'b1);
        chk({name, "/hold_idx"}, desc_idx_o, held_idx);
        chk({name, "/hold_desc"}, desc_o, held_desc);
        if (abort_mode == 1 && offered == 1 && hold_cnt == 1) begin
          dma_abort_i = 1'b1;
          phase = 3;
        end else if (hold_cnt == rdy_dly) begin
          desc_ready_i = 1'b1;
          phase = 2; wcnt = 0;
        end else begin
          hold_cnt++;
        end
      end
      @(negedge clk);
    end
    desc_ready_i = 1'b0; str_done_i = 1'b0; str_err_i = '0; dma_abort_i = 1'b0; dma_go_i = 1'b0;
    if (!finished) chk({name, "/timeout"}, 1'b0, 1'b1);
    chk({name, "/offered"}, offered, exp_offered);
    chk({name, "/mask"}, desc_done_o, exp_mask);
    chk({name, "/status"}, status_o, {exp_err.valid, 1'b1, 1'b0});
    chk({name, "/err"}, err_o, exp_err);
    chk({name, "/end_valid"}, desc_valid_o, 1'b0);
    @(negedge clk);
    chk({name, "/sticky"}, status_o, {exp_err.valid, 1'b1, 1'b0});
    chk({name, "/sticky_mask"}, desc_done_o, exp_mask);
  endtask

  initial begin
    s_dma_error_t e;
    int           ep, am, rd;
    rst = 1'b1; dma_go_i = 1'b0; dma_abort_i = 1'b0; dma_desc_i = '0; dma_desc_en_i = '0;
    desc_ready_i = 1'b0; str_done_i = 1'b0; str_err_i = '0;
    for (int i = 0; i < ND; i++) rand_desc(i, 16);
    #1;
    chk("reset/valid", desc_valid_o, 1'b0);
    chk("reset/outs", {desc_o, desc_idx_o, desc_done_o, status_o, err_o}, '0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // T1: two slots, 64 and 128 bytes
    rand_desc(0, 64); rand_desc(1, 128); cfg_en = 4'b0011;
    run_job("t1", 0, -1, 1, 10, 1'b0, 1'b0);
    // T2: slot 0 disabled
    cfg_en = 4'b0010;
    run_job("t2", 0, -1, 1, 4, 1'b0, 1'b0);
    // T3: zero-length slot 0
    rand_desc(0, 0); cfg_en = 4'b0011;
    run_job("t3", 0, -1, 0, 3, 1'b0, 1'b0);
    // T4: ready held low for 20 cycles
    rand_desc(0, 256);
    run_job("t4", 0, -1, 20, 5, 1'b0, 1'b0);
    // T5: two errors in slot 0 WAIT
    run_job("t5", 0, 0, 1, 6, 1'b0, 1'b0);
    // T6: abort in ISSUE, then abort in WAIT
    run_job("t6_issue", 1, -1, 100, 4, 1'b0, 1'b0);
    run_job("t6_wait", 2, -1, 0, 5, 1'b0, 1'b0);
    // Boundaries: nothing enabled, only empty slots, last slot only, go+abort together
    cfg_en = 4'b0000;
    run_job("none_en", 0, -1, 0, 3, 1'b0, 1'b0);
    for (int i = 0; i < ND; i++) rand_desc(i, 0);
    cfg_en = 4'b1111;
    run_job("all_zero", 0, -1, 0, 3, 1'b0, 1'b0);
    rand_desc(3, 4096); cfg_en = 4'b1000;
    run_job("last_only", 0, -1, 2, 3, 1'b1, 1'b1);

    // Randomized jobs
    for (int j = 0; j < 20; j++) begin
      for (int i = 0; i < ND; i++)
        rand_desc(i, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 4096));
      cfg_en = 4'($urandom);
      ep = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 2) : -1;
      am = (ep < 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      rd = (am == 1) ? 100 : $urandom_range(0, 3);
      run_job("rand", am, ep, rd, $urandom_range(3, 6), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
    end

    // Reset while a transfer is in WAIT, with an error already latched
    for (int i = 0; i < ND; i++) rand_desc(i, 32);
    cfg_en = 4'b0001;
    load_cfg();
    @(negedge clk); dma_go_i = 1'b1;
    @(negedge clk); dma_go_i = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (desc_valid_o) break;
      @(negedge clk);
    end
    chk("rst_wait/valid", desc_valid_o, 1'b1);
    desc_ready_i = 1'b1;
    @(negedge clk); desc_ready_i = 1'b0;
    e.valid = 1'b1; e.err_type = DMA_ALIGN_ERR; e.addr = 32'h0000_3000;
    str_err_i = e;
    @(negedge clk); str_err_i = '0;
    @(negedge clk);
    chk("rst_wait/err_pre", err_o, e);
    chk("rst_wait/active_pre", status_o, 3'b101);
    #2 rst = 1'b1;
    #1;
    chk("rst_wait/valid0", desc_valid_o, 1'b0);
    chk("rst_wait/outs0", {desc_o, desc_idx_o, desc_done_o, status_o, err_o}, '0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("rst_wait/idle", status_o, 3'b000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
